fdd_rotation: RTL

Disk-rotation emulator for the two-drive MSX floppy subsystem. It sits directly downstream of the FDD motor controller and consumes its per-drive `motor_run` flags. For each drive it models the spinning medium: angular position, the index hole, the sector currently under the head, and spin-up readiness. It presents the selected drive's INDEX, READY and sector number to the FDC-facing logic.

---
 rtl/fdd_rotation.sv | 113 +++++++++++
 1 files changed

// File: rtl/fdd_rotation.sv
// fdd_rotation: two-drive floppy rotation emulator (angle, index hole, sector, READY).
// Optional macro FDD_READY_SPINUP_EN: READY waits READY_REVS full revolutions after spin start.
module fdd_rotation #(
  parameter int ROT_MS     = 200,
  parameter int INDEX_MS   = 4,
  parameter int SECTORS    = 9,
  parameter int READY_REVS = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       msclk,
  input  logic       USEL,
  input  logic [1:0] motor_run,
  input  logic [1:0] disk_present,
  output logic       INDEXn,
  output logic       READYn,
  output logic [4:0] sector,
  output logic       index_pulse
);

  if (ROT_MS < 2 || ROT_MS > 255 || INDEX_MS >= ROT_MS || SECTORS < 1 || SECTORS > 31 ||
      SECTORS >= ROT_MS || READY_REVS < 1 || READY_REVS > 3) begin : g_param_check
    $error("fdd_rotation: parameter out of range");
  end

  localparam logic [7:0] ROT_LAST = 8'(ROT_MS - 1);
  localparam logic [8:0] ROT_W    = 9'(ROT_MS);
  localparam logic [8:0] SEC_STEP = 9'(SECTORS);
  localparam logic [4:0] SEC_LAST = 5'(SECTORS - 1);
  localparam logic [7:0] IDX_W    = 8'(INDEX_MS);

  logic [1:0]      spin;
  logic [1:0]      idx;
  logic [1:0]      rdy;
  logic [1:0][4:0] sec_all;

  assign spin = motor_run & disk_present;

  for (genvar i = 0; i < 2; i++) begin : g_drive
    logic [7:0] pos;
    logic [7:0] acc;
    logic [4:0] sec;
    logic [8:0] t;

    // Bresenham step: acc carries the fractional sector progress in units of 1/ROT_MS.
    assign t = {1'b0, acc} + SEC_STEP;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        pos <= '0;
        acc <= '0;
        sec <= '0;
      end else if (!spin[i]) begin
        pos <= '0;
        acc <= '0;
        sec <= '0;
      end else if (msclk) begin
        if (pos == ROT_LAST) begin
          pos <= '0;
          acc <= '0;
          sec <= '0;
        end else begin
          pos <= pos + 8'd1;
          if (t >= ROT_W) begin
            acc <= 8'(t - ROT_W);
            if (sec != SEC_LAST) sec <= sec + 5'd1;
          end else begin
            acc <= t[7:0];
          end
        end
      end
    end

    assign idx[i]     = spin[i] & (pos < IDX_W);
    assign sec_all[i] = sec;

`ifdef FDD_READY_SPINUP_EN
    localparam logic [1:0] REVS_MAX = 2'(READY_REVS);
    logic [1:0] revs;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        revs <= '0;
      end else if (!spin[i]) begin
        revs <= '0;
      end else if (msclk && pos == ROT_LAST && revs != REVS_MAX) begin
        revs <= revs + 2'd1;
      end
    end

    assign rdy[i] = spin[i] & (revs == REVS_MAX);
`else
    assign rdy[i] = spin[i];
`endif
  end

  // Outputs follow whichever drive USEL points at; the drives themselves never depend on USEL.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      INDEXn      <= 1'b1;
      READYn      <= 1'b1;
      sector      <= '0;
      index_pulse <= 1'b0;
    end else begin
      INDEXn      <= ~idx[USEL];
      READYn      <= ~rdy[USEL];
      sector      <= sec_all[USEL];
      index_pulse <= INDEXn & idx[USEL];
    end
  end

endmodule
